// File: rtl/note_sequencer_if.sv
// Song-ROM / buzzer bundle for the auto-play note sequencer.
// The sequencer takes the slave side; the controller, ROM and buzzer take the master side.
interface note_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              stop;
    logic              pause;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_data;
    logic [17:0]       freq;
    logic              tone_en;
    logic              busy;
    logic              done;
    logic [5:0]        cur_note;

    modport slave (
        input  start, stop, pause, mem_data,
        output mem_addr, freq, tone_en, busy, done, cur_note
    );

    modport master (
        output start, stop, pause, mem_data,
        input  mem_addr, freq, tone_en, busy, done, cur_note
    );
endinterface

// File: rtl/note_sequencer.sv
// Auto-play controller: walks the song ROM, times each note and gap, and drives the
// buzzer half-period. All outputs are registered.
module note_sequencer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int ADDR_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    note_sequencer_if.slave bus
);
    localparam longint MAX_PLAY  = 15 * longint'(BEAT_TICKS);
    localparam longint MAX_TICKS = (MAX_PLAY > longint'(GAP_TICKS)) ? MAX_PLAY : longint'(GAP_TICKS);
    localparam int     TIMER_W   = $clog2(MAX_TICKS + 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [5:0] END_CODE = 6'd63;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_GAP, S_DONE} state_t;

    // Half-period count for a note code; codes 1..21 are C..B over octaves 4..6.
    function automatic logic [17:0] half_period(input int code);
        int  oct;
        int  step;
        int  semis;
        real ratio;
        real f;
        if (code < 1 || code > 21) return 18'd0;
        oct  = (code - 1) / 7;
        step = (code - 1) % 7;
        case (step)
            0:       semis = -9;
            1:       semis = -7;
            2:       semis = -5;
            3:       semis = -4;
            4:       semis = -2;
            5:       semis = 0;
            default: semis = 2;
        endcase
        semis = semis + 12 * oct;
        ratio = 1.0;
        for (int i = 0; i < semis; i++) ratio = ratio * 1.0594630943592953;
        for (int i = 0; i > semis; i--) ratio = ratio / 1.0594630943592953;
        f = 440.0 * ratio;
        return 18'($rtoi($itor(CLK_HZ) / (2.0 * f) + 0.5) - 1);
    endfunction

    logic [17:0]        pitch_lut [64];
    logic [TIMER_W-1:0] beat_lut  [16];

    for (genvar g = 0; g < 64; g++) begin : g_pitch
        localparam logic [17:0] HP = half_period(g);
        assign pitch_lut[g] = HP;
    end

    // Timer loads hold duration-1 so PLAY lasts exactly beats*BEAT_TICKS cycles.
    for (genvar g = 0; g < 16; g++) begin : g_beat
        localparam longint TICKS = longint'((g == 0) ? 1 : g) * longint'(BEAT_TICKS) - 1;
        assign beat_lut[g] = TIMER_W'(TICKS);
    end

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [5:0]         code_q, code_d;
    logic [17:0]        freq_q, freq_d;
    logic               tone_en_q, tone_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [5:0]         cur_note_q, cur_note_d;
    logic               advance;
    logic               play_next;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        timer_d    = timer_q;
        code_d     = code_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_FETCH;
                    mem_addr_d = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (bus.mem_data[11:6] == END_CODE) begin
                    state_d    = S_DONE;
                    mem_addr_d = '0;
                end else begin
                    code_d  = bus.mem_data[11:6];
                    timer_d = beat_lut[bus.mem_data[5:2]];
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!bus.pause) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_W'(1);
                    end else if (GAP_TICKS > 0) begin
                        state_d = S_GAP;
                        timer_d = GAP_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!bus.pause) begin
                    if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
                    else               advance = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The song ends at the last ROM slot instead of wrapping to address 0.
        if (advance) begin
            if (mem_addr_q == '1) begin
                state_d    = S_DONE;
                mem_addr_d = '0;
            end else begin
                state_d    = S_FETCH;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
        end

        if (bus.stop) begin
            state_d    = S_IDLE;
            mem_addr_d = '0;
        end

        play_next  = (state_d == S_PLAY);
        freq_d     = play_next ? pitch_lut[code_d] : 18'd0;
        tone_en_d  = play_next && (code_d >= 6'd1) && (code_d <= 6'd21) && !bus.pause;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        cur_note_d = play_next ? code_d : 6'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            freq_q     <= '0;
            tone_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cur_note_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            freq_q     <= freq_d;
            tone_en_q  <= tone_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cur_note_q <= cur_note_d;
        end
    end

    // Timer and latched code are only meaningful once the FSM has loaded them.
    always_ff @(posedge clk) begin
        timer_q <= timer_d;
        code_q  <= code_d;
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.freq     = freq_q;
    assign bus.tone_en  = tone_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cur_note = cur_note_q;
endmodule
